// File: rtl/button_debounce_array.sv
// -----------------------------------------------------------------------------
// button_debounce_array
//
// Purpose:
//   N-channel push-button conditioner. Each channel has its own polarity
//   normalisation, 2-flop synchroniser, debounce counter, clean level output
//   and one-cycle press/release pulses. It sits between raw KEY/SW pins and the
//   control FSM.
//
// Ports:
//   Clk          in   1      system clock, all state on the rising edge
//   Reset        in   1      asynchronous, active-low reset
//   btn_raw      in   N_BTN  raw asynchronous button pins
//   btn_level    out  N_BTN  debounced level, 1 = pressed
//   btn_press    out  N_BTN  one-cycle pulse when btn_level rises (and on repeat)
//   btn_release  out  N_BTN  one-cycle pulse when btn_level falls
//
// Optional feature:
//   `define AUTOREPEAT_EN adds a per-channel hold counter. While a button stays
//   pressed, extra btn_press pulses fire HOLD_CYCLES after the press and then
//   every REPEAT_CYCLES. Without the macro no hold logic is generated.
// -----------------------------------------------------------------------------
module button_debounce_array #(
    parameter int N_BTN         = 3,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 500000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_BTN-1:0] w_pol;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] w_commit;
    logic [N_BTN-1:0] w_rpt;

    // After normalisation 1 always means pressed, so the released value of
    // the synchroniser flops is 0 regardless of pin polarity.
    assign w_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // A channel commits its new level on the cycle its count reaches the end
    // while the synced input still disagrees with the current level.
    always_comb begin
        w_commit = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_commit[i] = (r_sync2[i] != btn_level[i]) && (r_cnt[i] == STABLE_LAST);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_pol;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_BTN; i++) begin
                // Repeat pulses never coincide with a commit, so the commit
                // branch below can safely override the default.
                btn_press[i]   <= w_rpt[i];
                btn_release[i] <= 1'b0;
                if (r_sync2[i] == btn_level[i]) begin
                    // Any bounce back to the current level restarts the count.
                    r_cnt[i] <= '0;
                end else if (w_commit[i]) begin
                    btn_level[i]   <= r_sync2[i];
                    r_cnt[i]       <= '0;
                    btn_press[i]   <= r_sync2[i];
                    btn_release[i] <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold [N_BTN];
    logic [N_BTN-1:0]  r_rep;    // 1 once the first repeat has fired

    // The hold counter only runs while the level is 1 and is not about to
    // fall this cycle; the first interval is HOLD_CYCLES, later ones are
    // REPEAT_CYCLES.
    always_comb begin
        w_rpt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rpt[i] = btn_level[i] && !w_commit[i] &&
                       (r_hold[i] == (r_rep[i] ? REP_LAST : HOLD_LAST));
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rep <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_level[i] || w_commit[i]) begin
                    r_hold[i] <= '0;
                    r_rep[i]  <= 1'b0;
                end else if (w_rpt[i]) begin
                    r_hold[i] <= '0;
                    r_rep[i]  <= 1'b1;
                end else begin
                    r_hold[i] <= r_hold[i] + 1'b1;
                end
            end
        end
    end
`else
    // No auto-repeat: the hold timing parameters have no effect.
    logic w_unused_hold;
    assign w_rpt         = '0;
    assign w_unused_hold = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

endmodule

// File: tb/tb_button_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_array
//
// Directed bench for button_debounce_array with N_BTN=3, STABLE_CYCLES=4,
// ACTIVE_LOW=1, HOLD_CYCLES=10, REPEAT_CYCLES=3. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit after a rising edge.
// A raw edge therefore appears on the outputs after the 6th following edge.
// -----------------------------------------------------------------------------
module tb_button_debounce_array;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [2:0] btn_raw = 3'b111;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;

    int checks = 0;
    int failures = 0;

`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    // Press bits that may carry repeat pulses are excluded while other
    // channels are under test.
    localparam logic [2:0] PM3 = AR ? 3'b110 : 3'b111;
    localparam logic [2:0] PM4 = AR ? 3'b000 : 3'b111;

    button_debounce_array #(
        .N_BTN        (3),
        .CNT_W        (4),
        .STABLE_CYCLES(4),
        .ACTIVE_LOW   (1'b1),
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                       input logic [2:0] rel, input logic [2:0] pm);
        checks++;
        assert ({btn_level, btn_press & pm, btn_release} === {lvl, prs & pm, rel})
        else begin
            failures++;
            $error("FAIL %s observed lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=%b (press mask %b)",
                   tag, btn_level, btn_press, btn_release, lvl, prs, rel, pm);
        end
    endtask

    initial begin
        logic p;
        logic l;
        logic r;

        // 1: reset with all buttons released
        Reset   = 1'b0;
        btn_raw = 3'b111;
        tick();
        tick();
        chk("rst_hold", 3'b000, 3'b000, 3'b000, 3'b111);
        tick();
        chk("rst_hold2", 3'b000, 3'b000, 3'b000, 3'b111);
        Reset = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("post_rst", 3'b000, 3'b000, 3'b000, 3'b111);
        end

        // 2: clean press on channel 0
        btn_raw = 3'b110;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("s2_wait", 3'b000, 3'b000, 3'b000, 3'b111);
        end
        tick();
        chk("s2_press", 3'b001, 3'b001, 3'b000, 3'b111);
        tick();
        chk("s2_after", 3'b001, 3'b000, 3'b000, 3'b111);

        // 3: channel 1 bounces 0,1,0,1 for 2 cycles each, then settles at 0
        for (int b = 0; b < 4; b++) begin
            btn_raw = (b % 2 == 0) ? 3'b100 : 3'b110;
            tick();
            chk("s3_bounce", 3'b001, 3'b000, 3'b000, PM3);
            tick();
            chk("s3_bounce", 3'b001, 3'b000, 3'b000, PM3);
        end
        btn_raw = 3'b100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("s3_wait", 3'b001, 3'b000, 3'b000, PM3);
        end
        tick();
        chk("s3_press", 3'b011, 3'b010, 3'b000, PM3);
        tick();
        chk("s3_after", 3'b011, 3'b000, 3'b000, PM3);

        // 4: press channel 2, then release channels 0 and 2 on the same edge
        btn_raw = 3'b000;
        for (int c = 1; c <= 8; c++) tick();
        chk("s4_all_on", 3'b111, 3'b000, 3'b000, PM4);
        btn_raw = 3'b101;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("s4_wait", 3'b111, 3'b000, 3'b000, PM4);
        end
        tick();
        chk("s4_rel02", 3'b010, 3'b000, 3'b101, PM4);
        tick();
        chk("s4_after", 3'b010, 3'b000, 3'b000, PM4);
        btn_raw = 3'b111;
        for (int c = 1; c <= 5; c++) tick();
        tick();
        chk("s4_rel1", 3'b000, 3'b000, 3'b010, PM4);
        tick();
        chk("s4_idle", 3'b000, 3'b000, 3'b000, 3'b111);

        // 5: reset pulse in the middle of a press count, button kept held
        btn_raw = 3'b110;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("s5_count", 3'b000, 3'b000, 3'b000, 3'b111);
        end
        Reset = 1'b0;
        #1;
        chk("s5_in_rst", 3'b000, 3'b000, 3'b000, 3'b111);
        tick();
        chk("s5_in_rst2", 3'b000, 3'b000, 3'b000, 3'b111);
        Reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("s5_wait", 3'b000, 3'b000, 3'b000, 3'b111);
        end
        tick();
        chk("s5_press", 3'b001, 3'b001, 3'b000, 3'b111);
        tick();
        chk("s5_after", 3'b001, 3'b000, 3'b000, 3'b111);
        btn_raw = 3'b111;
        for (int c = 1; c <= 8; c++) tick();
        chk("s5_released", 3'b000, 3'b000, 3'b000, 3'b111);

        // 6: hold channel 0 for 30 cycles, then release
        btn_raw = 3'b110;
        for (int c = 1; c <= 30; c++) begin
            tick();
            l = (c >= 6);
            p = (c == 6) || (AR && c >= 16 && ((c - 16) % 3 == 0));
            chk("s6_hold", {2'b00, l}, {2'b00, p}, 3'b000, 3'b111);
        end
        btn_raw = 3'b111;
        for (int r0 = 1; r0 <= 12; r0++) begin
            tick();
            l = (r0 < 6);
            r = (r0 == 6);
            p = AR && (r0 == 1 || r0 == 4);
            chk("s6_release", {2'b00, l}, {2'b00, p}, {2'b00, r}, 3'b111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
